// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU execution unit:
// the alu_funct code points, the FSM state encoding and a small decode helper.
package alu_pkg;

    typedef enum logic [2:0] {
        FnAnd = 3'b000,
        FnOr  = 3'b001,
        FnAdd = 3'b010,
        FnXor = 3'b011,
        FnSll = 3'b100,
        FnSrl = 3'b101,
        FnSub = 3'b110,
        FnSlt = 3'b111
    } alu_funct_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    function automatic logic is_shift(input logic [2:0] funct);
        return (funct == FnSll) || (funct == FnSrl);
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between pipeline control (master) and the execution unit (slave).
interface alu_seq_exec_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             start;
    logic [2:0]       alu_funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_funct, a, b, shamt,
        input  result, zero, overflow, busy, done
    );

    modport slave (
        input  start, alu_funct, a, b, shamt,
        output result, zero, overflow, busy, done
    );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle logic/arithmetic core: AND/OR/ADD/XOR/SUB/SLT plus signed overflow.
// Shift codes are handled by the sequencer; they produce zero here.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       alu_funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    localparam int unsigned Msb = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
    assign sub_ovf = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_funct)
            FnAnd: result = a & b;
            FnOr:  result = a | b;
            FnXor: result = a ^ b;
            FnAdd: begin
                result   = sum;
                overflow = add_ovf;
            end
            FnSub: begin
                result   = diff;
                overflow = sub_ovf;
            end
            // Sign of the true difference survives wrap when corrected by the overflow bit.
            FnSlt: result = {{(WIDTH-1){1'b0}}, diff[Msb] ^ sub_ovf};
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execution unit: one-cycle logic/arithmetic ops, iterative one-bit-per-clock shifts,
// with registered result/zero/overflow and busy/done handshake to pipeline control.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_exec_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             req_shift;
    logic [WIDTH-1:0] core_result;
    logic             core_ovf;
    logic [WIDTH-1:0] shifted;

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .alu_funct (bus.alu_funct),
        .a         (bus.a),
        .b         (bus.b),
        .result    (core_result),
        .overflow  (core_ovf)
    );

    // start is only honoured outside SHIFT; it is never queued.
    assign accept    = bus.start && (state_q != StShift);
    assign req_shift = is_shift(bus.alu_funct);
    assign shifted   = left_q ? (shreg_q << 1) : (shreg_q >> 1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    if (req_shift && (bus.shamt != '0)) begin
                        state_d = StShift;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy = (state_q == StShift);
        bus.done = (state_q == StDone);
    end

    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;

    // Datapath next-state: result flags only change on a completion.
    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (accept) begin
            if (req_shift) begin
                if (bus.shamt == '0) begin
                    result_d = bus.b;
                    zero_d   = (bus.b == '0);
                    ovf_d    = 1'b0;
                end else begin
                    shreg_d = bus.b;
                    cnt_d   = bus.shamt;
                    left_d  = (bus.alu_funct == FnSll);
                end
            end else begin
                result_d = core_result;
                zero_d   = (core_result == '0);
                ovf_d    = core_ovf;
            end
        end else if (state_q == StShift) begin
            shreg_d = shifted;
            cnt_d   = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                result_d = shifted;
                zero_d   = (shifted == '0);
                ovf_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
